// File: rtl/msrv32_dmem_pkg.sv
// Shared encodings, FSM state type and address decode helper for the data-memory controller.
package msrv32_dmem_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StErr1,
    StErr2
  } dmem_state_e;

  // Unsigned 32-bit offset compare: addresses below base wrap to huge offsets and fail too.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] size_bytes);
    return (addr - base) < size_bytes;
  endfunction

endpackage

// File: rtl/msrv32_dmem_if.sv
// Core data-port bundle: address/write phase from the core, response back to it.
interface msrv32_dmem_if;
  logic [31:0] dmaddr_in;
  logic [31:0] dmdata_in;
  logic        dmwr_req_in;
  logic [3:0]  dmwr_mask_in;
  logic [1:0]  htrans_in;
  logic [31:0] data_out;
  logic        hready_out;
  logic        hresp_out;

  modport master (
    output dmaddr_in, dmdata_in, dmwr_req_in, dmwr_mask_in, htrans_in,
    input  data_out, hready_out, hresp_out
  );

  modport slave (
    input  dmaddr_in, dmdata_in, dmwr_req_in, dmwr_mask_in, htrans_in,
    output data_out, hready_out, hresp_out
  );
endinterface

// File: rtl/msrv32_dmem_array.sv
// Word-organised SRAM with byte-lane write enables, synchronous write, asynchronous read.
module msrv32_dmem_array #(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-masked write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we && be[i]) begin
        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Combinational read of the addressed word.
  always_comb begin
    rdata = mem[idx];
  end

endmodule

// File: rtl/msrv32_dmem_ctrl.sv
// Data-memory controller: AHB-Lite-style address/data phase decode onto a local SRAM.
module msrv32_dmem_ctrl
  import msrv32_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          ms_riscv32_mp_clk_in,
  input  logic          ms_riscv32_mp_rst_in,
  msrv32_dmem_if.slave  bus
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SIZE_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LOAD  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_e   state_q, state_d;
  logic          pend_q, pend_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic [3:0]    mask_q;
  logic [31:0]   wdata_q;

  logic          hready;
  logic          accept;
  logic          in_range;
  logic          complete;
  logic [AW-1:0] idx_d;
  logic [31:0]   rdata;

  assign in_range = addr_in_range(bus.dmaddr_in, BASE_ADDR, SIZE_BYTES);
  // Low address bits are dropped; the word index is the offset from base.
  assign idx_d    = AW'((bus.dmaddr_in - BASE_ADDR) >> 2);

  // State, counter and pending-phase flag.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q <= StIdle;
      pend_q  <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address-phase capture; write data travels with the address.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      mask_q  <= 4'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      addr_q  <= idx_d;
      wr_q    <= bus.dmwr_req_in;
      mask_q  <= bus.dmwr_mask_in;
      wdata_q <= bus.dmdata_in;
    end
  end

  // Next-state, wait counter and pending-phase logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = complete ? 1'b0 : pend_q;
    unique case (state_q)
      StIdle, StErr2: begin
        if (accept) begin
          if (!in_range) begin
            state_d = StErr1;
            pend_d  = 1'b0;
          end else if (WAIT_STATES > 0) begin
            state_d = StBusy;
            cnt_d   = WAIT_LOAD;
            pend_d  = 1'b0;
          end else begin
            state_d = StIdle;
            pend_d  = 1'b1;
          end
        end else if (state_q == StErr2) begin
          state_d = StIdle;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
          pend_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: begin
        state_d = StErr2;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Bus outputs and handshake decode.
  always_comb begin
    hready         = (state_q == StIdle) || (state_q == StErr2);
    accept         = bus.htrans_in[1] && hready;
    complete       = pend_q && hready;
    bus.hready_out = hready;
    bus.hresp_out  = (state_q == StErr1) || (state_q == StErr2);
    bus.data_out   = (complete && !wr_q) ? rdata : 32'd0;
  end

  msrv32_dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (ms_riscv32_mp_clk_in),
    .we    (complete && wr_q),
    .be    (mask_q),
    .idx   (addr_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );

endmodule
